// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic light monitor slice:
//   light codes, direction and phase encodings, error bit indices
//   and the error vector width.
package traffic_pkg;

  localparam int ERR_W = 7;

  // One-hot light codes: [2]=red, [1]=yellow, [0]=green
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  // Bit positions inside err_flags
  localparam int ERR_INVALID        = 0;
  localparam int ERR_CONFLICT       = 1;
  localparam int ERR_SKIP_YELLOW    = 2;
  localparam int ERR_BAD_ORDER      = 3;
  localparam int ERR_YELLOW_TIME    = 4;
  localparam int ERR_GREEN_SHORT    = 5;
  localparam int ERR_ALLRED_TIMEOUT = 6;

endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if
//   Bundles the observed light codes, the clear strobe and the monitor
//   results.
//   master : drives north/south/east/west_light and clear, reads results
//   slave  : the monitor; reads lights/clear, drives active_dir, phase,
//            dwell, err_flags, err_pulse, rotations
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  import traffic_pkg::*;

  logic [2:0]       north_light;
  logic [2:0]       south_light;
  logic [2:0]       east_light;
  logic [2:0]       west_light;
  logic             clear;
  logic [1:0]       active_dir;
  logic [1:0]       phase;
  logic [CNT_W-1:0] dwell;
  logic [ERR_W-1:0] err_flags;
  logic             err_pulse;
  logic [15:0]      rotations;

  modport master (
    output north_light, south_light, east_light, west_light, clear,
    input  active_dir, phase, dwell, err_flags, err_pulse, rotations
  );

  modport slave (
    input  north_light, south_light, east_light, west_light, clear,
    output active_dir, phase, dwell, err_flags, err_pulse, rotations
  );

endinterface

// File: rtl/traffic_light_decode.sv
// traffic_light_decode
//   Classifies one 3-bit light code.
//   code_i    : light code, [2]=red [1]=yellow [0]=green
//   is_red_o  : code is exactly red
//   is_yel_o  : code is exactly yellow
//   is_grn_o  : code is exactly green
//   invalid_o : code is none of the three legal one-hot values
module traffic_light_decode
  import traffic_pkg::*;
(
  input  logic [2:0] code_i,
  output logic       is_red_o,
  output logic       is_yel_o,
  output logic       is_grn_o,
  output logic       invalid_o
);

  assign is_red_o  = (code_i == LT_RED);
  assign is_yel_o  = (code_i == LT_YEL);
  assign is_grn_o  = (code_i == LT_GRN);
  assign invalid_o = ~(is_red_o | is_yel_o | is_grn_o);

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Observes a four-way controller's lights, tracks the active direction
//   through ALLRED -> GREEN -> YELLOW -> ALLRED, times each phase and
//   raises sticky violation flags.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   mon   : traffic_light_monitor_if.slave (lights, clear in; results out)
//   Optional macro TLM_ALLRED_WATCHDOG_EN builds the all-red watchdog
//   (err_flags[6]) and its ALLRED_MAX parameter; otherwise bit 6 is 0.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 6
`ifdef TLM_ALLRED_WATCHDOG_EN
  , parameter int ALLRED_MAX = 16
`endif
) (
  input logic                    clock,
  input logic                    reset,
  traffic_light_monitor_if.slave mon
);

  // Thresholds are compared against dwell+1, which needs one extra bit
  localparam logic [CNT_W:0] GREEN_MIN_C  = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] YELLOW_MIN_C = (CNT_W+1)'(YELLOW_MIN);
  localparam logic [CNT_W:0] YELLOW_MAX_C = (CNT_W+1)'(YELLOW_MAX);
`ifdef TLM_ALLRED_WATCHDOG_EN
  localparam logic [CNT_W:0] ALLRED_MAX_C = (CNT_W+1)'(ALLRED_MAX);
`endif

  logic [3:0][2:0] lights;
  logic [3:0]      is_red, is_yel, is_grn, invalid;

  assign lights = {mon.west_light, mon.east_light, mon.south_light, mon.north_light};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      traffic_light_decode u_dec (
        .code_i   (lights[gi]),
        .is_red_o (is_red[gi]),
        .is_yel_o (is_yel[gi]),
        .is_grn_o (is_grn[gi]),
        .invalid_o(invalid[gi])
      );
    end
  endgenerate

  phase_e           phase_q, phase_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, dwell_sat;
  logic [CNT_W:0]   dwell_inc;
  logic [ERR_W-1:0] err_flags_q, err_flags_d, err_set;
  logic             err_pulse_q, err_pulse_d;
  logic [15:0]      rot_q, rot_d;
  logic             rot_inc;
  logic             yel_over_q, yel_over_d;
`ifdef TLM_ALLRED_WATCHDOG_EN
  logic             ar_over_q, ar_over_d;
`endif

  logic [3:0] nonred;
  logic       any_invalid, multi_nonred, all_red, sole_grn;
  dir_e       sole_dir;

  assign nonred       = is_yel | is_grn;
  assign any_invalid  = |invalid;
  // Clearing the lowest set bit leaves something only if two or more are set
  assign multi_nonred = |(nonred & (nonred - 4'd1));
  assign all_red      = &is_red;
  assign sole_grn     = |is_grn;
  assign dwell_inc    = {1'b0, dwell_q} + 1'b1;
  assign dwell_sat    = (&dwell_q) ? dwell_q : dwell_inc[CNT_W-1:0];

  always_comb begin
    sole_dir = DIR_N;
    for (int i = 3; i >= 0; i--) begin
      if (nonred[i]) sole_dir = dir_e'(i[1:0]);
    end
  end

  always_comb begin
    phase_d    = phase_q;
    dir_d      = dir_q;
    dwell_d    = dwell_sat;
    err_set    = '0;
    rot_inc    = 1'b0;
    yel_over_d = yel_over_q;
`ifdef TLM_ALLRED_WATCHDOG_EN
    ar_over_d  = ar_over_q;
`endif

    if (any_invalid || multi_nonred) begin
      // Garbage on the lights: flag it and restart from a safe ALLRED
      err_set[ERR_INVALID]  = any_invalid;
      err_set[ERR_CONFLICT] = multi_nonred;
      phase_d = PH_ALLRED;
      dwell_d = '0;
    end else begin
      case (phase_q)
        PH_ALLRED: begin
          if (all_red) begin
`ifdef TLM_ALLRED_WATCHDOG_EN
            if (dwell_inc > ALLRED_MAX_C && !ar_over_q) begin
              err_set[ERR_ALLRED_TIMEOUT] = 1'b1;
              ar_over_d = 1'b1;
            end
`else
            err_set[ERR_ALLRED_TIMEOUT] = 1'b0;
`endif
          end else begin
            dir_d   = sole_dir;
            dwell_d = '0;
            if (sole_grn) begin
              phase_d = PH_GREEN;
            end else begin
              phase_d = PH_YELLOW;
              err_set[ERR_BAD_ORDER] = 1'b1;
            end
          end
        end
        PH_GREEN: begin
          if (all_red) begin
            err_set[ERR_SKIP_YELLOW] = 1'b1;
            phase_d = PH_ALLRED;
            dwell_d = '0;
          end else if (sole_dir != dir_q) begin
            err_set[ERR_CONFLICT] = 1'b1;
            phase_d = PH_ALLRED;
            dwell_d = '0;
          end else if (!sole_grn) begin
            if (dwell_inc < GREEN_MIN_C) err_set[ERR_GREEN_SHORT] = 1'b1;
            phase_d = PH_YELLOW;
            dwell_d = '0;
          end
        end
        PH_YELLOW: begin
          if (all_red) begin
            if (dwell_inc < YELLOW_MIN_C) err_set[ERR_YELLOW_TIME] = 1'b1;
            rot_inc = 1'b1;
            phase_d = PH_ALLRED;
            dwell_d = '0;
          end else if (sole_dir != dir_q) begin
            err_set[ERR_CONFLICT] = 1'b1;
            phase_d = PH_ALLRED;
            dwell_d = '0;
          end else if (sole_grn) begin
            err_set[ERR_BAD_ORDER] = 1'b1;
            phase_d = PH_GREEN;
            dwell_d = '0;
          end else if (dwell_inc > YELLOW_MAX_C && !yel_over_q) begin
            err_set[ERR_YELLOW_TIME] = 1'b1;
            yel_over_d = 1'b1;
          end
        end
        default: begin
          phase_d = PH_ALLRED;
          dwell_d = '0;
        end
      endcase
    end

    // dwell_d is zero only on a phase (re)entry, which re-arms the
    // once-per-phase overrun detectors
    if (dwell_d == '0) begin
      yel_over_d = 1'b0;
`ifdef TLM_ALLRED_WATCHDOG_EN
      ar_over_d  = 1'b0;
`endif
    end
  end

  // A violation in the same cycle as clear survives the clear
  assign err_flags_d = (mon.clear ? '0 : err_flags_q) | err_set;
  assign err_pulse_d = |(err_flags_d & ~err_flags_q);
  assign rot_d       = (mon.clear ? 16'd0 : rot_q) + {15'd0, rot_inc};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q     <= PH_ALLRED;
      dir_q       <= DIR_N;
      dwell_q     <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      rot_q       <= '0;
      yel_over_q  <= 1'b0;
`ifdef TLM_ALLRED_WATCHDOG_EN
      ar_over_q   <= 1'b0;
`endif
    end else begin
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      dwell_q     <= dwell_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
      rot_q       <= rot_d;
      yel_over_q  <= yel_over_d;
`ifdef TLM_ALLRED_WATCHDOG_EN
      ar_over_q   <= ar_over_d;
`endif
    end
  end

  assign mon.phase      = phase_q;
  assign mon.active_dir = dir_q;
  assign mon.dwell      = dwell_q;
  assign mon.err_flags  = err_flags_q;
  assign mon.err_pulse  = err_pulse_q;
  assign mon.rotations  = rot_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
//   Directed table of {lights, clear, repeat count, expected outputs}
//   followed by hand-written sequences for the watchdog, dwell
//   saturation and an asynchronous reset in the middle of a phase.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  traffic_light_monitor_if #(.CNT_W(8)) mon_if ();

  traffic_light_monitor #(
    .CNT_W(8), .GREEN_MIN(8), .YELLOW_MIN(2), .YELLOW_MAX(6)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .mon  (mon_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  n, s, e, w;
    logic        clr;
    int          reps;
    logic [1:0]  ph;
    logic [1:0]  dir;
    logic [7:0]  dw;
    logic [6:0]  fl;
    logic        pu;
    logic [15:0] rot;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic [2:0] n, s, e, w, input logic clr,
                              input int reps, input logic [1:0] ph, dir,
                              input logic [7:0] dw, input logic [6:0] fl,
                              input logic pu, input logic [15:0] rot);
    vec_t v;
    v.n = n; v.s = s; v.e = e; v.w = w; v.clr = clr; v.reps = reps;
    v.ph = ph; v.dir = dir; v.dw = dw; v.fl = fl; v.pu = pu; v.rot = rot;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ph, dir,
                           input logic [7:0] dw, input logic [6:0] fl,
                           input logic pu, input logic [15:0] rot);
    check({tag, ".phase"},     32'(mon_if.phase),      32'(ph));
    check({tag, ".dir"},       32'(mon_if.active_dir), 32'(dir));
    check({tag, ".dwell"},     32'(mon_if.dwell),      32'(dw));
    check({tag, ".err_flags"}, 32'(mon_if.err_flags),  32'(fl));
    check({tag, ".err_pulse"}, 32'(mon_if.err_pulse),  32'(pu));
    check({tag, ".rotations"}, 32'(mon_if.rotations),  32'(rot));
    $display("%s: phase=%0d dir=%0d dwell=%0d flags=%b pulse=%0d rot=%0d", tag,
             mon_if.phase, mon_if.active_dir, mon_if.dwell, mon_if.err_flags,
             mon_if.err_pulse, mon_if.rotations);
  endtask

  task automatic apply(input logic [2:0] n, s, e, w, input logic clr, input int reps);
    mon_if.north_light = n;
    mon_if.south_light = s;
    mon_if.east_light  = e;
    mon_if.west_light  = w;
    mon_if.clear       = clr;
    for (int i = 0; i < reps; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] wd_bit;

  initial begin
`ifdef TLM_ALLRED_WATCHDOG_EN
    wd_bit = 7'd64;
`else
    wd_bit = 7'd0;
`endif
    //            N  S  E  W  clr reps ph dir dw fl  pu rot
    tbl[0]  = mk(G, R, R, R, 0, 1,  1, 0, 0, 0,  0, 0);
    tbl[1]  = mk(G, R, R, R, 0, 9,  1, 0, 9, 0,  0, 0);
    tbl[2]  = mk(Y, R, R, R, 0, 1,  2, 0, 0, 0,  0, 0);
    tbl[3]  = mk(Y, R, R, R, 0, 2,  2, 0, 2, 0,  0, 0);
    tbl[4]  = mk(R, R, R, R, 0, 1,  0, 0, 0, 0,  0, 1);
    tbl[5]  = mk(R, R, R, R, 0, 2,  0, 0, 2, 0,  0, 1);
    tbl[6]  = mk(R, R, G, R, 0, 10, 1, 2, 9, 0,  0, 1);
    tbl[7]  = mk(R, R, R, R, 0, 1,  0, 2, 0, 4,  1, 1);
    tbl[8]  = mk(R, R, R, R, 0, 1,  0, 2, 1, 4,  0, 1);
    tbl[9]  = mk(G, G, R, R, 0, 1,  0, 2, 0, 6,  1, 1);
    tbl[10] = mk(G, G, R, R, 1, 1,  0, 2, 0, 2,  0, 0);
    tbl[11] = mk(R, R, R, R, 0, 1,  0, 2, 1, 2,  0, 0);
    tbl[12] = mk(R, R, R, 3'b110, 0, 1, 0, 2, 0, 3, 1, 0);
    tbl[13] = mk(R, R, R, G, 0, 4,  1, 3, 3, 3,  0, 0);
    tbl[14] = mk(R, R, R, Y, 0, 1,  2, 3, 0, 35, 1, 0);
    tbl[15] = mk(R, R, R, Y, 0, 5,  2, 3, 5, 35, 0, 0);
    tbl[16] = mk(R, R, R, Y, 0, 1,  2, 3, 6, 35, 0, 0);
    tbl[17] = mk(R, R, R, Y, 0, 1,  2, 3, 7, 51, 1, 0);
    tbl[18] = mk(R, R, R, Y, 0, 1,  2, 3, 8, 51, 0, 0);
    tbl[19] = mk(R, R, R, R, 0, 1,  0, 3, 0, 51, 0, 1);
    tbl[20] = mk(R, R, R, R, 1, 1,  0, 3, 1, 0,  0, 0);
    tbl[21] = mk(R, Y, R, R, 0, 1,  2, 1, 0, 8,  1, 0);
    tbl[22] = mk(R, R, R, R, 0, 1,  0, 1, 0, 24, 1, 1);
    tbl[23] = mk(R, G, R, R, 0, 1,  1, 1, 0, 24, 0, 1);
    tbl[24] = mk(R, Y, R, R, 0, 1,  2, 1, 0, 56, 1, 1);
    tbl[25] = mk(R, G, R, R, 0, 1,  1, 1, 0, 56, 0, 1);
    tbl[26] = mk(R, R, G, R, 0, 1,  0, 1, 0, 58, 1, 1);
    tbl[27] = mk(R, R, R, R, 1, 1,  0, 1, 1, 0,  0, 0);

    // Reset held low for two cycles
    mon_if.north_light = R;
    mon_if.south_light = R;
    mon_if.east_light  = R;
    mon_if.west_light  = R;
    mon_if.clear       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Dwell counts up in ALLRED after release
    for (int k = 1; k <= 3; k++) begin
      apply(R, R, R, R, 0, 1);
      check_all($sformatf("post_reset_%0d", k), 0, 0, 8'(k), 0, 0, 0);
    end

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].clr, tbl[i].reps);
      check_all($sformatf("row%0d", i), tbl[i].ph, tbl[i].dir, tbl[i].dw,
                tbl[i].fl, tbl[i].pu, tbl[i].rot);
    end

    // All-red watchdog boundary: dwell 16 is fine, the 17th all-red cycle trips it
    apply(R, R, R, R, 0, 15);
    check_all("wd_edge", 0, 1, 16, 0, 0, 0);
    apply(R, R, R, R, 0, 1);
    check_all("wd_trip", 0, 1, 17, wd_bit, (wd_bit != 0), 0);
    apply(R, R, R, R, 0, 1);
    check_all("wd_hold", 0, 1, 18, wd_bit, 0, 0);

    // Dwell saturates at 255
    apply(R, R, R, R, 0, 240);
    check_all("dwell_sat", 0, 1, 255, wd_bit, 0, 0);
    apply(R, R, R, R, 0, 1);
    check_all("dwell_sat_hold", 0, 1, 255, wd_bit, 0, 0);

    // Asynchronous reset in the middle of a green phase
    apply(G, R, R, R, 0, 3);
    check_all("pre_reset_green", 1, 0, 2, wd_bit, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0);
    mon_if.north_light = Y;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // First post-reset sample is judged from ALLRED: yellow is out of order
    apply(Y, R, R, R, 0, 1);
    check_all("after_reset_yellow", 2, 0, 0, 8, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
